// File: rtl/dec_pkg.sv
// Shared state/mode encodings and sizing helper for the dec_scan decoder.
package dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Dwell counter width: enough bits for 0..DWELL-1, never less than one bit.
   function automatic int cnt_width(input int dwell);
      return (dwell > 1) ? $clog2(dwell) : 1;
   endfunction

endpackage

// File: rtl/dec_core.sv
// Purely combinational N-to-2^N one-hot decoder.
module dec_core #(
   parameter int N = 3
) (
   input  logic [N-1:0]      i_idx,
   output logic [(1<<N)-1:0] o_onehot
);

   localparam int W = 1 << N;

   assign o_onehot = W'(1) << i_idx;

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with a direct (load/sel) mode and a scan mode that
// walks the active output through every position with a programmable dwell.
module dec_scan
   import dec_pkg::*;
#(
   parameter int N     = 3,
   parameter int DWELL = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              mode,
   input  logic              load,
   input  logic [N-1:0]      sel,
   output logic [(1<<N)-1:0] D,
   output logic [N-1:0]      idx,
   output logic              wrap
);

   localparam int               W        = 1 << N;
   localparam int               CNT_W    = cnt_width(DWELL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [N-1:0]     IDX_LAST = '1;

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [N-1:0]     r_idx;
   logic [W-1:0]     r_d;
   logic             r_wrap;

   state_e           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [N-1:0]     w_idx_nxt;
   logic             w_act_nxt;
   logic             w_wrap_nxt;
   logic [W-1:0]     w_onehot;

   // The decoder sees the next index so D and idx land on the same edge.
   dec_core #(.N(N)) u_core (
      .i_idx    (w_idx_nxt),
      .o_onehot (w_onehot)
   );

   // Next-state, next-index, dwell counter and wrap decisions.
   always_comb begin
      // NOTE: every target gets a default first so no path through this block
      // leaves a signal unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_act_nxt   = (r_d != '0);
      w_wrap_nxt  = 1'b0;

      if (!en) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
         w_act_nxt   = 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE, ST_DIRECT: begin
               if (mode == MODE_SCAN) begin
                  // Entering scan always restarts at position 0 with a fresh dwell.
                  w_state_nxt = ST_SCAN;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = '0;
                  w_act_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ST_DIRECT;
                  if (load) begin
                     w_idx_nxt = sel;
                     w_act_nxt = 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               if (mode == MODE_DIRECT) begin
                  // Leaving scan freezes the current position; load is ignored this cycle.
                  w_state_nxt = ST_DIRECT;
               end else if (r_cnt == CNT_LAST) begin
                  w_cnt_nxt  = '0;
                  w_idx_nxt  = r_idx + N'(1);
                  w_wrap_nxt = (r_idx == IDX_LAST);
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_act_nxt   = 1'b0;
            end
         endcase
      end
   end

   // State, counter, index, one-hot output and wrap registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_d     <= '0;
         r_wrap  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_d     <= w_act_nxt ? w_onehot : '0;
         r_wrap  <= w_wrap_nxt;
      end
   end

   assign D    = r_d;
   assign idx  = r_idx;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench: three dec_scan instances (DWELL 4, 2, 1) share stimulus; a
// cycle-level reference model predicts outputs, a monitor pops and compares.
module tb_dec_scan;

   localparam int N  = 3;
   localparam int SZ = 1 << N;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             mode;
   logic             load;
   logic [N-1:0]     sel;
   logic [SZ-1:0]    d   [3];
   logic [N-1:0]     ix  [3];
   logic             wr  [3];

   int n_checks = 0;
   int n_fail   = 0;

   dec_scan #(.N(N), .DWELL(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel),
      .D(d[0]), .idx(ix[0]), .wrap(wr[0]));
   dec_scan #(.N(N), .DWELL(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel),
      .D(d[1]), .idx(ix[1]), .wrap(wr[1]));
   dec_scan #(.N(N), .DWELL(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel),
      .D(d[2]), .idx(ix[2]), .wrap(wr[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: scan position is derived from elapsed cycles since scan start.
   int dw    [3] = '{4, 2, 1};
   int m_st  [3];   // 0 idle, 1 direct, 2 scan
   int m_t   [3];   // cycles elapsed since scan (re)start
   int m_idx [3];
   bit m_act [3];
   bit m_wrap[3];

   typedef struct packed {
      logic [2:0][SZ-1:0] d;
      logic [2:0][N-1:0]  ix;
      logic [2:0]         wr;
   } exp_t;

   exp_t q[$];

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_st[k] = 0; m_t[k] = 0; m_idx[k] = 0; m_act[k] = 1'b0; m_wrap[k] = 1'b0;
      end
   endtask

   task automatic model_step(input logic e, input logic m, input logic l, input logic [N-1:0] s);
      for (int k = 0; k < 3; k++) begin
         m_wrap[k] = 1'b0;
         if (!e) begin
            m_st[k] = 0; m_act[k] = 1'b0; m_idx[k] = 0;
         end else if (m) begin
            if (m_st[k] != 2) begin
               m_st[k] = 2;
               m_t[k]  = 0;
            end else begin
               m_t[k]++;
            end
            m_idx[k]  = (m_t[k] / dw[k]) % SZ;
            m_act[k]  = 1'b1;
            m_wrap[k] = (m_t[k] != 0) && (m_t[k] % (dw[k] * SZ) == 0);
         end else begin
            if (m_st[k] == 2) begin
               m_st[k] = 1;
            end else begin
               m_st[k] = 1;
               if (l) begin
                  m_idx[k] = int'(s);
                  m_act[k] = 1'b1;
               end
            end
         end
      end
   endtask

   // Apply one cycle of stimulus (also releases reset) and queue the prediction.
   task automatic drive(input logic e, input logic m, input logic l, input logic [N-1:0] s);
      exp_t x;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      en = e; mode = m; load = l; sel = s;
      model_step(e, m, l, s);
      for (int k = 0; k < 3; k++) begin
         x.d[k]  = m_act[k] ? (SZ'(1) << m_idx[k]) : '0;
         x.ix[k] = N'(m_idx[k]);
         x.wr[k] = m_wrap[k];
      end
      q.push_back(x);
   endtask

   // Monitor: outputs update every edge, so pop and compare once per cycle.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            x = q.pop_front();
            for (int k = 0; k < 3; k++) begin
               check($sformatf("D dut%0d", k),    d[k],  x.d[k]);
               check($sformatf("idx dut%0d", k),  ix[k], x.ix[k]);
               check($sformatf("wrap dut%0d", k), wr[k], x.wr[k]);
            end
         end
      end
   end

   initial begin
      logic r_mode;
      rst_n = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel = '0;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset D dut%0d", k),    d[k],  0);
         check($sformatf("reset idx dut%0d", k),  ix[k], 0);
         check($sformatf("reset wrap dut%0d", k), wr[k], 0);
      end
      drive(1'b0, 1'b0, 1'b0, 3'd0);

      // Direct load of 5, then sel changes without load must be ignored.
      drive(1'b1, 1'b0, 1'b1, 3'd5);
      drive(1'b1, 1'b0, 1'b0, 3'd2);
      drive(1'b1, 1'b0, 1'b0, 3'd7);

      // Direct sweep with a load every cycle.
      for (int i = 0; i < SZ; i++) drive(1'b1, 1'b0, 1'b1, N'(i));

      // Long scan: covers several full periods for every dwell.
      for (int i = 0; i < 70; i++) drive(1'b1, 1'b1, 1'b1, N'($urandom));

      // Scan to direct with a same-cycle load (mode change wins), then a real load.
      drive(1'b1, 1'b0, 1'b1, 3'd3);
      drive(1'b1, 1'b0, 1'b0, 3'd3);
      drive(1'b1, 1'b0, 1'b1, 3'd6);

      // Direct to scan restarts at position 0.
      for (int i = 0; i < 19; i++) drive(1'b1, 1'b1, 1'b0, 3'd0);

      // Drop enable mid-scan, then re-enter scan.
      drive(1'b0, 1'b1, 1'b1, 3'd4);
      drive(1'b0, 1'b0, 1'b1, 3'd4);
      for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b0, 3'd0);

      // Randomized traffic with occasional mode flips and enable drops.
      r_mode = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) r_mode = ~r_mode;
         drive(($urandom_range(0, 19) != 0), r_mode, 1'($urandom_range(0, 1)), N'($urandom));
      end

      // Run scan until the DWELL=4 instance sits on index 6, then reset between edges.
      drive(1'b0, 1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 64 && !(m_st[0] == 2 && m_idx[0] == 6); i++)
         drive(1'b1, 1'b1, 1'b0, 3'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("async D dut%0d", k),    d[k],  0);
         check($sformatf("async idx dut%0d", k),  ix[k], 0);
         check($sformatf("async wrap dut%0d", k), wr[k], 0);
      end
      model_reset();
      // Release into direct with no load: outputs must stay zero.
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 3'd5);

      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      #3;
      check("scoreboard drain", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dec_scan.md
# dec_scan

Parametrised, registered N-to-2^N one-hot decoder with two modes. Direct mode decodes a loaded select value. Scan mode steps the active output through every position, holding each for a programmable dwell time, for row/digit strobing. It is the sequential successor to the team's fixed 3-to-8 combinational decoder and sits between control logic and strobe-driven peripherals.

## Interface
- `N`, default 3: select width; output width is 2^N.
- `DWELL`, default 4: cycles each output stays active in scan mode; legal range is ≥1.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `en`, input, 1: global enable. When low, outputs are forced to zero and state returns to IDLE.
- `mode`, input, 1: 0 = DIRECT, 1 = SCAN. Sampled every cycle while `en` = 1.
- `load`, input, 1: in DIRECT, captures `sel` on this cycle.
- `sel`, input, N: value to decode; `sel[N-1]` is the MSB.
- `D`, output, 2^N: registered one-hot output. `D[i]` = 1 when the active index is i.
- `idx`, output, N: registered binary index currently driven. Valid while `D` ≠ 0.
- `wrap`, output, 1: one-cycle pulse on the cycle `idx` steps from 2^N-1 to 0 in SCAN.

## Operation
- The active index and `D` are always consistent: `D == (1 << idx)` whenever `D` ≠ 0.
- **States:** IDLE, DIRECT, SCAN.
- **IDLE** (entered on reset or `en` = 0):
  - `D` = 0, `idx` = 0, dwell counter = 0.
  - With `en` = 1 and `mode` = 0, go to DIRECT.
  - With `en` = 1 and `mode` = 1, go to SCAN starting at index 0.
- **DIRECT:**
  - `load` = 1 latches `sel` into `idx` and drives `D` = 1 << `sel`.
  - Without `load`, `D` holds its last value.
  - First entry from IDLE with no `load` leaves `D` = 0.
  - A change on `sel` without `load` has no effect.
- **SCAN:**
  - The dwell counter counts 0 … DWELL-1.
  - At DWELL-1 the counter resets and `idx` increments modulo 2^N.
  - `wrap` asserts for the one cycle `idx` becomes 0 after being 2^N-1.
  - `load` and `sel` are ignored.
- **Mode change while enabled:**
  - DIRECT→SCAN restarts the scan at index 0 with the counter cleared.
  - SCAN→DIRECT keeps the current `D` and `idx` until the next `load`.
- **`en` falling:** IDLE on the next edge; `D` = 0, `wrap` = 0.
- **Simultaneous events:** `en` = 0 dominates `mode` and `load`. A mode change dominates `load` on the same cycle.
- **Reset values:** `D` = 0, `idx` = 0, `wrap` = 0, state IDLE, counter 0.
- **DWELL = 1:** `idx` advances every cycle.
- **Counter width:** max(1, clog2(DWELL)), no overflow path.

## Timing
- Reset is asynchronous; outputs clear immediately on `rst_n` falling. Release takes effect on the first `clk` edge with `rst_n` high.
- DIRECT latency: `load` sampled at edge k gives `D`/`idx` valid after edge k (1-cycle registered latency).
- SCAN entry: `mode` = 1 sampled at edge k gives `D[0]` = 1 after edge k. The index advances after edges k+DWELL, k+2·DWELL, and so on.
- Full scan period is DWELL·2^N cycles. `wrap` is high for exactly 1 cycle per period, coincident with `D[0]` rising.
- Reset mid-scan restarts from IDLE; no partial dwell is preserved.
- No combinational path from inputs to outputs.

## Structure
- **Package `dec_pkg`:** state encoding constants (IDLE = 0, DIRECT = 1, SCAN = 2), mode constants (`MODE_DIRECT` = 0, `MODE_SCAN` = 1).
- **Sub-module `dec_core`:** purely combinational N-to-2^N decoder (index → one-hot). `dec_scan` instantiates it on the next-index value and registers its output.
- Top-level logic: the state register, dwell counter, index register and `wrap` register.

## Test plan
- Reset, then `en` = 1, `mode` = 0, `load` = 1, `sel` = 3'b101 (N = 3) → one cycle later `D` = 8'b0010_0000 and `idx` = 5. Hold `load` = 0 and change `sel` to 2 → `D` unchanged.
- Sweep DIRECT `sel` = 0…7 with `load` every cycle → `D` = 8'h01, 02, 04, … 80, each one cycle after its load.
- SCAN with N = 3, DWELL = 2, 20 cycles:
  - `D[0]` is high for cycles 1–2, `D[1]` for 3–4, …, `D[7]` for 15–16.
  - `D[0]` is high again at cycle 17, with `wrap` = 1 at cycle 17 only.
- SCAN with DWELL = 1 → `idx` increments every cycle, 0→7→0, and `wrap` pulses every 8 cycles.
- Mid-scan at `idx` = 4: drop `en` → `D` = 0 next cycle. Re-raise `en` with `mode` = 1 → restart at `D[0]`.
- Assert `rst_n` = 0 asynchronously between edges during SCAN at `idx` = 6 → `D` = 0 and `wrap` = 0 immediately. After release with `mode` = 0 and no `load` → `D` stays 0.
